// File: rtl/fmap_pkg.sv
// Shared definitions for the fmap pad read path: FSM state encodings,
// skid depth and the sideband bits that ride along with each tap.
package fmap_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam int SKID_DEPTH = 2;

   typedef struct packed {
      logic last_tap;
      logic last;
   } fmap_side_t;

endpackage

// File: rtl/fmap_rd_skid.sv
// Two-entry valid/ready buffer between the pad read pipeline and the MAC lane.
// It has no input backpressure; the reader's credit logic keeps it from overflowing.
module fmap_rd_skid
   import fmap_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [SKID_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             push;
   logic             pop;

   assign push        = in_valid_i && (count_q != 2'(SKID_DEPTH));
   assign pop         = out_valid_o && out_ready_i;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign count_o     = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/fmap_pad_reader.sv
// Read-side sequencer for the PE feature pad: walks stride-1 convolution windows
// and streams taps to the MAC lane. FMAP_RD_PERF_CNT_EN adds the stall_cnt output.
module fmap_pad_reader
   import fmap_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_W     = 8,
   parameter int WADDR_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_start,
   input  logic [WADDR_W-1:0]    weight_num,
   input  logic [ADDR_W-1:0]     pixel_num,
   input  logic [ADDR_W-1:0]     pixel_point,
   input  logic                  pad_data_ready,
   input  logic                  fmap_ready_to_pe,
   output logic [ADDR_W-1:0]     raddra_ifmap,
   input  logic [DATA_WIDTH-1:0] fmap_out,
   input  logic                  pe_ready,
   output logic                  pe_valid,
   output logic [DATA_WIDTH-1:0] pe_data,
   output logic                  pe_last_tap,
   output logic                  pe_last,
   output logic                  rd_busy,
   output logic                  rd_done,
   output logic                  cfg_err
`ifdef FMAP_RD_PERF_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int CW = (ADDR_W > WADDR_W) ? ADDR_W : WADDR_W;

   logic [1:0]            state_q, state_d;
   logic [ADDR_W-1:0]     raddr_q, raddr_d;
   logic [ADDR_W-1:0]     win_addr_q, win_addr_d;
   logic [ADDR_W-1:0]     win_q, win_d;
   logic [ADDR_W-1:0]     nwin_q, nwin_d;
   logic [WADDR_W-1:0]    tap_q, tap_d;
   logic [WADDR_W-1:0]    wnum_q, wnum_d;
   logic                  complete_q, complete_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  rd_done_q, rd_done_d;
   logic                  inflight_q;
   fmap_side_t            inflight_side_q, issue_side;
   logic [CW-1:0]         wnum_ext, pnum_ext;
   logic                  start_ok, cfg_bad, can_proceed, pop, issue, last_tap, last_win;
   logic [1:0]            skid_cnt;
   logic [DATA_WIDTH+1:0] skid_dout;

   assign start_ok    = rd_start && (state_q == ST_IDLE);
   assign wnum_ext    = CW'(weight_num);
   assign pnum_ext    = CW'(pixel_num);
   assign cfg_bad     = (weight_num == '0) || (wnum_ext > pnum_ext);
   assign can_proceed = pad_data_ready || complete_q;
   assign pop         = pe_valid && pe_ready;
   assign last_tap    = (tap_q == wnum_q - WADDR_W'(1));
   assign last_win    = (win_q == nwin_q - ADDR_W'(1));
   assign issue_side  = '{last_tap: last_tap, last: last_tap && last_win};

   // Credit counts the skid after this cycle's pop, so a continuously ready
   // lane sees one beat per cycle while a stalled lane never overflows the skid.
   assign issue = (state_q == ST_READ) && can_proceed &&
                  (({1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop}) < 3'(SKID_DEPTH));

   // Sequencer: counters advance window-major, tap-ascending, one address per issue.
   always_comb begin
      state_d    = state_q;
      raddr_d    = raddr_q;
      win_addr_d = win_addr_q;
      win_d      = win_q;
      nwin_d     = nwin_q;
      tap_d      = tap_q;
      wnum_d     = wnum_q;
      cfg_err_d  = cfg_err_q;
      rd_done_d  = 1'b0;
      complete_d = start_ok ? fmap_ready_to_pe : (complete_q || fmap_ready_to_pe);
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               cfg_err_d = cfg_bad;
               if (cfg_bad) begin
                  rd_done_d = 1'b1;
               end else begin
                  state_d    = ST_WAIT;
                  raddr_d    = pixel_point;
                  win_addr_d = pixel_point;
                  win_d      = '0;
                  tap_d      = '0;
                  wnum_d     = weight_num;
                  nwin_d     = ADDR_W'(pnum_ext - wnum_ext + CW'(1));
               end
            end
         end
         ST_WAIT: begin
            if (can_proceed) state_d = ST_READ;
         end
         ST_READ: begin
            if (!can_proceed) begin
               state_d = ST_WAIT;
            end else if (issue) begin
               if (!last_tap) begin
                  tap_d   = tap_q + WADDR_W'(1);
                  raddr_d = raddr_q + ADDR_W'(1);
               end else if (last_win) begin
                  state_d = ST_DRAIN;
               end else begin
                  tap_d      = '0;
                  win_d      = win_q + ADDR_W'(1);
                  win_addr_d = win_addr_q + ADDR_W'(1);
                  raddr_d    = win_addr_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && (skid_cnt == {1'b0, pop})) begin
               state_d   = ST_IDLE;
               rd_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         raddr_q         <= '0;
         win_addr_q      <= '0;
         win_q           <= '0;
         nwin_q          <= '0;
         tap_q           <= '0;
         wnum_q          <= '0;
         complete_q      <= 1'b0;
         cfg_err_q       <= 1'b0;
         rd_done_q       <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_side_q <= '0;
      end else begin
         state_q         <= state_d;
         raddr_q         <= raddr_d;
         win_addr_q      <= win_addr_d;
         win_q           <= win_d;
         nwin_q          <= nwin_d;
         tap_q           <= tap_d;
         wnum_q          <= wnum_d;
         complete_q      <= complete_d;
         cfg_err_q       <= cfg_err_d;
         rd_done_q       <= rd_done_d;
         inflight_q      <= issue;
         inflight_side_q <= issue_side;
      end
   end

   // Pad data returns one cycle after its address; the sideband is delayed to match.
   fmap_rd_skid #(
      .WIDTH(DATA_WIDTH + 2)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (inflight_q),
      .in_data_i  ({fmap_out, inflight_side_q}),
      .out_valid_o(pe_valid),
      .out_ready_i(pe_ready),
      .out_data_o (skid_dout),
      .count_o    (skid_cnt)
   );

   assign {pe_data, pe_last_tap, pe_last} = skid_dout;
   assign raddra_ifmap = raddr_q;
   assign rd_busy      = (state_q != ST_IDLE);
   assign rd_done      = rd_done_q;
   assign cfg_err      = cfg_err_q;

`ifdef FMAP_RD_PERF_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if (((pe_valid && !pe_ready) || (state_q == ST_WAIT)) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule
